byte_word_packer: RTL and testbench

Packs a stream of 8-bit bytes into 32-bit words, first-accepted byte in bits [31:24], last in [7:0], the layout the four-byte max reducer consumes on its 32-bit data input. Sits between a byte-wide source (UART/GPIO capture) and word-wide consumers. Uses valid/ready on both sides, supports partial-word flush, and optionally tracks the per-word maximum byte incrementally.

---
 rtl/byte_word_packer.sv | 91 +++++++++
 tb/tb_byte_word_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs accepted bytes MSB-first into 32-bit words with
// valid/ready on both sides and partial-word flush. Define WORD_MAX_EN to track per-word max byte.
module byte_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_nbytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_max
);

  logic [1:0]  count;
  logic [23:0] staging;
  logic        byte_acc;
  logic        word_acc;
  logic        complete;
  logic [31:0] word_next;

  // The output slot frees up in the same cycle the consumer takes the word.
  assign in_ready = ~out_valid | out_ready;
  assign byte_acc = in_valid & in_ready;
  assign word_acc = out_valid & out_ready;
  assign complete = byte_acc & (in_last | (count == 2'd3));

  // NOTE: every comb output gets a value on every path (or a default first) so no latch is inferred.
  always_comb begin
    word_next[31:24] = (count == 2'd0) ? in_data : staging[23:16];
    word_next[23:16] = (count == 2'd1) ? in_data :
                       (count >  2'd1) ? staging[15:8] : PAD_BYTE;
    word_next[15:8]  = (count == 2'd2) ? in_data :
                       (count >  2'd2) ? staging[7:0]  : PAD_BYTE;
    word_next[7:0]   = (count == 2'd3) ? in_data : PAD_BYTE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      staging    <= 24'h0;
      out_data   <= 32'h0;
      out_nbytes <= 3'd0;
      out_valid  <= 1'b0;
    end else if (complete) begin
      out_data   <= word_next;
      out_nbytes <= {1'b0, count} + 3'd1;
      out_valid  <= 1'b1;
      count      <= 2'd0;
      staging    <= 24'h0;
    end else begin
      if (byte_acc) begin
        case (count)
          2'd0:    staging[23:16] <= in_data;
          2'd1:    staging[15:8]  <= in_data;
          default: staging[7:0]   <= in_data;
        endcase
        count <= count + 2'd1;
      end
      if (word_acc) out_valid <= 1'b0;
    end
  end

`ifdef WORD_MAX_EN
  logic [7:0] run_max;
  logic [7:0] max_next;

  // The first byte of a word loads directly so the previous word's max never leaks in.
  assign max_next = (count == 2'd0 || in_data > run_max) ? in_data : run_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max <= 8'h0;
      out_max <= 8'h0;
    end else if (complete) begin
      run_max <= 8'h0;
      out_max <= max_next;
    end else if (byte_acc) begin
      run_max <= max_next;
    end
  end
`else
  assign out_max = 8'h00;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// Self-checking bench for byte_word_packer: directed cases plus random traffic
// against a queue-based word model; two DUTs differ only in PAD_BYTE.
module tb_byte_word_packer;

  localparam logic [7:0] PAD_A = 8'h00;
  localparam logic [7:0] PAD_B = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, out_ready;
  logic        in_ready, in_ready_b;
  logic [31:0] out_data, out_data_b;
  logic [2:0]  out_nbytes, out_nbytes_b;
  logic        out_valid, out_valid_b;
  logic [7:0]  out_max, out_max_b;

  always #5 clk = ~clk;

  byte_word_packer #(.PAD_BYTE(PAD_A)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_nbytes(out_nbytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max));

  byte_word_packer #(.PAD_BYTE(PAD_B)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_nbytes(out_nbytes_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_max(out_max_b));

  typedef struct packed {
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [2:0]  nbytes;
    logic [7:0]  max;
  } word_t;

  logic [7:0]  cur_q[$];
  word_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] held_data;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] exp_max(input logic [7:0] m);
`ifdef WORD_MAX_EN
    return m;
`else
    return 8'h00;
`endif
  endfunction

  // Reference word: bytes in arrival order from the top lane down, pad fills the rest.
  function automatic word_t build_word();
    word_t w;
    logic [7:0] m = 8'h00;
    w.data_a = 32'h0;
    w.data_b = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w.data_a = {w.data_a[23:0], (i < cur_q.size()) ? cur_q[i] : PAD_A};
      w.data_b = {w.data_b[23:0], (i < cur_q.size()) ? cur_q[i] : PAD_B};
      if (i < cur_q.size() && cur_q[i] > m) m = cur_q[i];
    end
    w.nbytes = 3'(cur_q.size());
    w.max    = exp_max(m);
    return w;
  endfunction

  // Evaluated mid-cycle, before the edge that commits this cycle's handshakes.
  task automatic evaluate();
    word_t w;
    check("in_ready", {31'h0, in_ready}, {31'h0, ~out_valid | out_ready});
    check("in_ready_b", {31'h0, in_ready_b}, {31'h0, in_ready});
    check("out_valid_b", {31'h0, out_valid_b}, {31'h0, out_valid});
    if (prev_stall) begin
      check("hold_valid", {31'h0, out_valid}, 32'h1);
      check("hold_data", out_data, held_data);
    end
    if (rst) begin
      cur_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
      return;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", out_data, 32'hxxxx_xxxx);
      end else begin
        w = exp_q.pop_front();
        check("data", out_data, w.data_a);
        check("data_pad_ff", out_data_b, w.data_b);
        check("nbytes", {29'h0, out_nbytes}, {29'h0, w.nbytes});
        check("max", {24'h0, out_max}, {24'h0, w.max});
        check("max_b", {24'h0, out_max_b}, {24'h0, w.max});
      end
    end
    if (in_valid && in_ready) begin
      cur_q.push_back(in_data);
      if (in_last || cur_q.size() == 4) begin
        exp_q.push_back(build_word());
        cur_q.delete();
      end
    end
    prev_stall = out_valid && !out_ready;
    held_data  = out_data;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic r, input logic rs);
    in_valid = v; in_data = d; in_last = l; out_ready = r; rst = rs;
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
  endtask

  // Directed check of the word just loaded, one cycle after its completing byte.
  task automatic expect_word(input string tag, input logic [31:0] da, input logic [31:0] db,
                             input logic [2:0] n, input logic [7:0] m);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_data"}, out_data, da);
    check({tag, "_data_ff"}, out_data_b, db);
    check({tag, "_nbytes"}, {29'h0, out_nbytes}, {29'h0, n});
    check({tag, "_max"}, {24'h0, out_max}, {24'h0, exp_max(m)});
  endtask

  initial begin
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0; rst = 1;
    @(posedge clk); #1;
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_nbytes", {29'h0, out_nbytes}, 32'h0);
    check("rst_max", {24'h0, out_max}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Full word, back-to-back bytes.
    cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    expect_word("full", 32'h11223344, 32'h11223344, 3'd4, 8'h44);

    // Two-byte flush.
    cycle(1'b1, 8'hA0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
    expect_word("flush2", 32'hA0050000, 32'hA005FFFF, 3'd2, 8'hA0);

    // Single-byte flush: pad never counts toward the max.
    cycle(1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    expect_word("flush1", 32'h7F000000, 32'h7FFFFFFF, 3'd1, 8'h7F);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Stall with a pending word, then release with a completing byte in the same cycle.
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    expect_word("stall", 32'h10C32030, 32'h10C32030, 3'd4, 8'hC3);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    expect_word("no_bubble", 32'h5A000000, 32'h5AFFFFFF, 3'd1, 8'h5A);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset mid-word discards staged bytes.
    cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    cycle(1'b1, 8'h09, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h08, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h06, 1'b0, 1'b1, 1'b0);
    expect_word("after_rst", 32'h09080706, 32'h09080706, 3'd4, 8'h09);

    // Random traffic with gaps, back-pressure and rare resets.
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 999) == 0);
    end

    // Drain: everything completed must have come out exactly once.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("drain_queue", exp_q.size(), 32'h0);
    check("drain_valid", {31'h0, out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
